// File: rtl/comparador_n_pkg.sv
// ============================================================================
// Module   : comparador_n_pkg
// Purpose  : FSM state encodings shared by the comparador_n block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package comparador_n_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_SCAN = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/comparador_cell.sv
// ============================================================================
// Module   : comparador_cell
// Purpose  : Combinational compare of one candidate against the running maximum.
//            With COMPARADOR_THRESH_EN, also flags whether candidate >= threshold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador_cell
  import comparador_n_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] cand_i,
  input  logic [W-1:0] max_i,
`ifdef COMPARADOR_THRESH_EN
  input  logic [W-1:0] thresh_i,
  output logic         qual_o,
`endif
  output logic         gt_o,
  output logic         eq_o
);

  assign gt_o = (cand_i > max_i);
  assign eq_o = (cand_i == max_i);

`ifdef COMPARADOR_THRESH_EN
  assign qual_o = (cand_i >= thresh_i);
`endif

endmodule

`default_nettype wire

// File: rtl/comparador_n.sv
// ============================================================================
// Module   : comparador_n
// Purpose  : Sequential N-channel maximum finder, one channel per cycle, with
//            winner mask/count and tie flag. Optional COMPARADOR_THRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador_n
  import comparador_n_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [N*W-1:0]             bus_i,
`ifdef COMPARADOR_THRESH_EN
  input  logic [W-1:0]               thresh_i,
`endif
  output logic                       busy_o,
  output logic                       done_o,
  output logic [W-1:0]               max_val_o,
  output logic [N-1:0]               win_mask_o,
  output logic [$clog2(N+1)-1:0]     win_cnt_o,
  output logic                       tie_o
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N+1);
  localparam logic [KW-1:0] K_LAST = KW'(N-1);

  logic [ST_W-1:0] state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N*W-1:0]  snap_q, snap_d;
  logic [W-1:0]    run_max_q, run_max_d;
  logic [N-1:0]    run_mask_q, run_mask_d;
  logic [CW-1:0]   run_cnt_q, run_cnt_d;
  logic            have_q, have_d;
  logic [W-1:0]    max_val_q, max_val_d;
  logic [N-1:0]    win_mask_q, win_mask_d;
  logic [CW-1:0]   win_cnt_q, win_cnt_d;
  logic            done_q, done_d;

  logic [W-1:0]    w_chan [N];
  logic [W-1:0]    w_cand;
  logic [N-1:0]    w_onehot;
  logic            w_gt, w_eq, w_qual;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign w_chan[i] = snap_q[i*W +: W];
  end

  assign w_cand   = w_chan[k_q];
  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << k_q;

`ifdef COMPARADOR_THRESH_EN
  logic [W-1:0] thr_q, thr_d;

  comparador_cell #(.W(W)) u_cell (
    .cand_i   (w_cand),
    .max_i    (run_max_q),
    .thresh_i (thr_q),
    .qual_o   (w_qual),
    .gt_o     (w_gt),
    .eq_o     (w_eq)
  );
`else
  assign w_qual = 1'b1;

  comparador_cell #(.W(W)) u_cell (
    .cand_i (w_cand),
    .max_i  (run_max_q),
    .gt_o   (w_gt),
    .eq_o   (w_eq)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      snap_q     <= '0;
      run_max_q  <= '0;
      run_mask_q <= '0;
      run_cnt_q  <= '0;
      have_q     <= 1'b0;
      max_val_q  <= '0;
      win_mask_q <= '0;
      win_cnt_q  <= '0;
      done_q     <= 1'b0;
`ifdef COMPARADOR_THRESH_EN
      thr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      snap_q     <= snap_d;
      run_max_q  <= run_max_d;
      run_mask_q <= run_mask_d;
      run_cnt_q  <= run_cnt_d;
      have_q     <= have_d;
      max_val_q  <= max_val_d;
      win_mask_q <= win_mask_d;
      win_cnt_q  <= win_cnt_d;
      done_q     <= done_d;
`ifdef COMPARADOR_THRESH_EN
      thr_q      <= thr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    snap_d     = snap_q;
    run_max_d  = run_max_q;
    run_mask_d = run_mask_q;
    run_cnt_d  = run_cnt_q;
    have_d     = have_q;
    max_val_d  = max_val_q;
    win_mask_d = win_mask_q;
    win_cnt_d  = win_cnt_q;
    done_d     = 1'b0;
`ifdef COMPARADOR_THRESH_EN
    thr_d      = thr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_SCAN;
          k_d        = '0;
          snap_d     = bus_i;
          run_max_d  = '0;
          run_mask_d = '0;
          run_cnt_d  = '0;
          have_d     = 1'b0;
`ifdef COMPARADOR_THRESH_EN
          thr_d      = thresh_i;
`endif
        end
      end
      ST_SCAN: begin
        // have_q distinguishes a genuine 0 maximum from "nothing qualified yet"
        if (w_qual) begin
          if (!have_q || w_gt) begin
            run_max_d  = w_cand;
            run_mask_d = w_onehot;
            run_cnt_d  = CW'(1);
            have_d     = 1'b1;
          end else if (w_eq) begin
            run_mask_d = run_mask_q | w_onehot;
            run_cnt_d  = run_cnt_q + CW'(1);
          end
        end
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        max_val_d  = run_max_q;
        win_mask_d = run_mask_q;
        win_cnt_d  = run_cnt_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == ST_SCAN);
    done_o     = done_q;
    max_val_o  = max_val_q;
    win_mask_o = win_mask_q;
    win_cnt_o  = win_cnt_q;
    tie_o      = (win_cnt_q > CW'(1));
  end

endmodule

`default_nettype wire

// File: tb/tb_comparador_n.sv
// ============================================================================
// Module   : tb_comparador_n
// Purpose  : Randomized self-checking bench for comparador_n (N=4, W=7) against
//            a two-pass max/popcount reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparador_n;

  localparam int N  = 4;
  localparam int W  = 7;
  localparam int CW = $clog2(N+1);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N*W-1:0]     bus;
  logic [W-1:0]       thresh;
  logic               busy_o, done_o, tie_o;
  logic [W-1:0]       max_val_o;
  logic [N-1:0]       win_mask_o;
  logic [CW-1:0]      win_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  comparador_n #(.N(N), .W(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .bus_i      (bus),
`ifdef COMPARADOR_THRESH_EN
    .thresh_i   (thresh),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .max_val_o  (max_val_o),
    .win_mask_o (win_mask_o),
    .win_cnt_o  (win_cnt_o),
    .tie_o      (tie_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first find the max among qualifying channels, then collect ties
  task automatic model(input logic [N*W-1:0] b, input logic [W-1:0] thr,
                       output logic [W-1:0] mx, output logic [N-1:0] mk, output int cnt);
    logic [W-1:0] v;
    bit found;
    mx = '0; mk = '0; cnt = 0; found = 0;
    for (int i = 0; i < N; i++) begin
      v = b[i*W +: W];
      if (v >= thr) begin
        if (!found || v > mx) mx = v;
        found = 1;
      end
    end
    if (found) begin
      for (int i = 0; i < N; i++) begin
        v = b[i*W +: W];
        if (v >= thr && v == mx) begin
          mk[i] = 1'b1;
          cnt++;
        end
      end
    end
  endtask

  function automatic logic [N*W-1:0] rand_bus();
    logic [N*W-1:0] b;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < N; i++) begin
      if (mode == 0) b[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      else if (mode == 1) b[i*W +: W] = W'($urandom_range(0, 2));
      else b[i*W +: W] = W'($urandom_range(98, 100));
    end
    return b;
  endfunction

  task automatic run_cmp(input logic [N*W-1:0] b, input logic [W-1:0] thr, input bit disturb);
    logic [W-1:0] e_max;
    logic [N-1:0] e_mask;
    int e_cnt, cycles, busy_cnt, extra;
    bit got;
`ifdef COMPARADOR_THRESH_EN
    model(b, thr, e_max, e_mask, e_cnt);
`else
    model(b, '0, e_max, e_mask, e_cnt);
`endif
    @(negedge clk);
    bus = b; thresh = thr; start = 1'b1;
    cycles = 0; busy_cnt = 0; got = 0;
    while (!got && cycles < 4*N + 10) begin
      @(posedge clk); #1;
      cycles++;
      if (busy_o) busy_cnt++;
      if (done_o) got = 1;
      else begin
        start = disturb && (cycles <= 2);
        if (disturb) begin
          bus = rand_bus();
          thresh = W'($urandom_range(0, (1 << W) - 1));
        end
      end
    end
    start = 1'b0;
    check("latency", 64'(cycles - 1), 64'(N + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(N));
    check("max_val", 64'(max_val_o), 64'(e_max));
    check("win_mask", 64'(win_mask_o), 64'(e_mask));
    check("win_cnt", 64'(win_cnt_o), 64'(e_cnt));
    check("tie", 64'(tie_o), 64'(e_cnt > 1));
    extra = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      if (done_o) extra++;
    end
    check("single_done", 64'(extra), 64'(0));
    check("held_max", 64'(max_val_o), 64'(e_max));
    check("held_mask", 64'(win_mask_o), 64'(e_mask));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
    check({tag, "_max"},  64'(max_val_o), 64'(0));
    check({tag, "_mask"}, 64'(win_mask_o), 64'(0));
    check({tag, "_cnt"},  64'(win_cnt_o), 64'(0));
    check({tag, "_tie"},  64'(tie_o), 64'(0));
  endtask

  initial begin
    int extra;
    rst = 1'b1; start = 1'b0; bus = '0; thresh = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk); rst = 1'b0;

    run_cmp({7'd0, 7'd0, 7'd0, 7'd100}, 7'd0, 1'b0);
    run_cmp({7'd25, 7'd100, 7'd100, 7'd100}, 7'd0, 1'b0);
    run_cmp({7'd0, 7'd50, 7'd50, 7'd25}, 7'd0, 1'b0);
    run_cmp({7'd0, 7'd0, 7'd0, 7'd0}, 7'd0, 1'b0);
    run_cmp({7'd127, 7'd127, 7'd127, 7'd127}, 7'd0, 1'b0);
    run_cmp({7'd3, 7'd90, 7'd7, 7'd90}, 7'd0, 1'b1);

`ifdef COMPARADOR_THRESH_EN
    run_cmp({7'd100, 7'd100, 7'd50, 7'd50}, 7'd60, 1'b0);
    run_cmp({7'd25, 7'd50, 7'd50, 7'd25}, 7'd60, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      run_cmp(rand_bus(), W'($urandom_range(0, 100)), 1'($urandom_range(0, 1)));
    end

    // Abort mid-scan: outputs cleared and no Done pulse afterwards
    @(negedge clk);
    bus = {7'd9, 7'd8, 7'd7, 7'd6}; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_cleared("abort");
    extra = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      if (done_o) extra++;
    end
    check("abort_no_done", 64'(extra), 64'(0));

    // Reset beats a simultaneous start
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    check("rst_over_start_busy", 64'(busy_o), 64'(0));

    run_cmp({7'd42, 7'd11, 7'd42, 7'd5}, 7'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
